// File: rtl/rep3_serial_tx_if.sv
// rep3_serial_tx_if: valid/ready word handshake between data source and transmitter
interface rep3_serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] din;
  logic din_valid;
  logic din_ready;
  modport master(output din, din_valid, input din_ready);
  modport slave(input din, din_valid, output din_ready);
endinterface

// File: rtl/rep3_serial_tx.sv
// rep3_serial_tx: framed LSB-first serializer holding each frame bit for REP cycles
module rep3_serial_tx #(
  parameter int DATA_W = 8,
  parameter int REP = 3
) (
  input  logic clk,
  input  logic rst_n,
  rep3_serial_tx_if.slave bus,
  output logic tx,
  output logic busy,
  output logic done
);
  localparam int RW = REP > 1 ? $clog2(REP) : 1;
  localparam int BW = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic [RW-1:0] rep_cnt, rep_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic tx_n, rep_last, bit_last;
  assign rep_last = rep_cnt == RW'(REP - 1);
  assign bit_last = bit_cnt == BW'(DATA_W - 1);
  assign busy = state != IDLE;
  assign done = state == STOP && rep_last;
  assign bus.din_ready = state == IDLE;
  always_comb begin
    state_n = state;
    shift_n = shift;
    bit_n = bit_cnt;
    rep_n = (state == IDLE || rep_last) ? '0 : rep_cnt + 1'b1;
    case (state)
      IDLE: if (bus.din_valid) begin
        state_n = START;
        shift_n = bus.din;
        bit_n = '0;
      end
      START: state_n = rep_last ? DATA : START;
      DATA: if (rep_last) begin
        shift_n = shift >> 1;
        bit_n = bit_last ? '0 : bit_cnt + 1'b1;
        state_n = bit_last ? STOP : DATA;
      end
      default: state_n = rep_last ? IDLE : STOP;
    endcase
    // tx is registered from next-state so it lines up with the state it encodes
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shift <= '0;
      rep_cnt <= '0;
      bit_cnt <= '0;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      shift <= shift_n;
      rep_cnt <= rep_n;
      bit_cnt <= bit_n;
      tx <= tx_n;
    end
  end
endmodule

// File: tb/tb_rep3_serial_tx.sv
// tb_rep3_serial_tx: directed frame checks plus majority-decoding scoreboard for two parameterisations
module tb_rep3_serial_tx;
  logic clk = 1'b0;
  logic rst_n;
  logic tx, busy, done, tx2, busy2, done2;
  int vectors = 0;
  int errors = 0;
  logic [7:0] q1 [$];
  logic [3:0] q2 [$];
  logic [29:0] smp1;
  logic [5:0] smp2;
  logic [7:0] w1;
  logic [3:0] w2;
  int n1 = 0;
  int n2 = 0;
  rep3_serial_tx_if #(.DATA_W(8)) bus ();
  rep3_serial_tx_if #(.DATA_W(4)) bus2 ();
  rep3_serial_tx #(.DATA_W(8), .REP(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .tx(tx), .busy(busy), .done(done));
  rep3_serial_tx #(.DATA_W(4), .REP(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2), .tx(tx2), .busy(busy2), .done(done2));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic maj(input logic [31:0] v, input int base, input int rep);
    int ones = 0;
    for (int i = 0; i < rep; i++) ones += int'(v[base + i]);
    return ones > rep / 2;
  endfunction
  function automatic logic exp_bit(input logic [7:0] w, input int c);
    int s = (c - 1) / 3;
    return s == 0 ? 1'b0 : s == 9 ? 1'b1 : w[s - 1];
  endfunction
  // majority-vote receivers: decode each frame and compare against the scoreboard
  always @(negedge clk) begin
    if (!rst_n) n1 = 0;
    else if (n1 > 0 || tx === 1'b0) begin
      smp1[n1] = tx;
      check("busy1", busy, 1);
      check("done1", done, n1 == 29);
      n1++;
      if (n1 == 30) begin
        n1 = 0;
        check("start1", maj(32'(smp1), 0, 3), 0);
        check("stop1", maj(32'(smp1), 27, 3), 1);
        for (int s = 0; s < 8; s++) w1[s] = maj(32'(smp1), 3 * (s + 1), 3);
        if (q1.size() == 0) check("sb1_empty", 1, 0);
        else check("rx1", w1, q1.pop_front());
      end
    end
  end
  always @(negedge clk) begin
    if (!rst_n) n2 = 0;
    else if (n2 > 0 || tx2 === 1'b0) begin
      smp2[n2] = tx2;
      check("busy2", busy2, 1);
      check("done2", done2, n2 == 5);
      n2++;
      if (n2 == 6) begin
        n2 = 0;
        check("start2", maj(32'(smp2), 0, 1), 0);
        check("stop2", maj(32'(smp2), 5, 1), 1);
        for (int s = 0; s < 4; s++) w2[s] = maj(32'(smp2), s + 1, 1);
        if (q2.size() == 0) check("sb2_empty", 1, 0);
        else check("rx2", w2, q2.pop_front());
      end
    end
  end
  task automatic frame1(input logic [7:0] w, input bit glitch);
    bus.din = w;
    bus.din_valid = 1'b1;
    q1.push_back(w);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      bus.din_valid = glitch && c == 12;
      if (glitch && c == 12) bus.din = 8'h3C;
      check("tx", tx, exp_bit(w, c));
      check("busy", busy, 1);
      check("done", done, c == 30);
      check("rdy", bus.din_ready, 0);
    end
    @(negedge clk);
    check("rdy_end", bus.din_ready, 1);
    check("tx_idle", tx, 1);
    check("busy_end", busy, 0);
  endtask
  task automatic send1(input logic [7:0] w);
    int t = 0;
    bus.din = w;
    bus.din_valid = 1'b1;
    while (!bus.din_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("hs1_timeout", t < 100, 1);
    q1.push_back(w);
    @(negedge clk);
  endtask
  task automatic send2(input logic [3:0] w);
    int t = 0;
    bus2.din = w;
    bus2.din_valid = 1'b1;
    while (!bus2.din_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("hs2_timeout", t < 100, 1);
    q2.push_back(w);
    @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [5:0] sw_exp;
    rst_n = 1'b0;
    bus.din = '0;
    bus.din_valid = 1'b0;
    bus2.din = '0;
    bus2.din_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdy", bus.din_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_tx", tx, 1);
    check("rel_rdy", bus.din_ready, 1);
    frame1(8'hA5, 1'b0);
    @(negedge clk);
    frame1(8'h5A, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("no_frame_busy", busy, 0);
      check("no_frame_tx", tx, 1);
    end
    bus.din = 8'h00;
    bus.din_valid = 1'b1;
    q1.push_back(8'h00);
    for (int c = 1; c <= 61; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.din = 8'hFF;
        q1.push_back(8'hFF);
      end
      if (c == 32) bus.din_valid = 1'b0;
      check("b2b_tx", tx, c <= 30 ? exp_bit(8'h00, c) : c == 31 ? 1'b1 : exp_bit(8'hFF, c - 31));
      check("b2b_rdy", bus.din_ready, c == 31);
    end
    @(negedge clk);
    bus.din = 8'h0F;
    bus.din_valid = 1'b1;
    q1.push_back(8'h0F);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      bus.din_valid = 1'b0;
      check("mid_tx", tx, exp_bit(8'h0F, c));
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_rdy", bus.din_ready, 1);
    q1.delete();
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_nodone", done, 0);
    end
    rst_n = 1'b1;
    frame1(8'h81, 1'b0);
    for (int i = 0; i < 6; i++) send1(8'($urandom));
    bus.din_valid = 1'b0;
    sw_exp = 6'b110010;
    bus2.din = 4'b1001;
    bus2.din_valid = 1'b1;
    q2.push_back(4'b1001);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus2.din_valid = 1'b0;
      check("sw_tx", tx2, sw_exp[c - 1]);
      check("sw_done", done2, c == 6);
    end
    @(negedge clk);
    check("sw_rdy", bus2.din_ready, 1);
    check("sw_idle", tx2, 1);
    for (int i = 0; i < 12; i++) send2(4'($urandom));
    bus2.din_valid = 1'b0;
    repeat (250) @(negedge clk);
    check("sb1_drain", q1.size(), 0);
    check("sb2_drain", q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
